// File: rtl/fire_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fire_ctrl_pkg
// Description : Shared state encodings, requester IDs and timing defaults for
//               the fire request scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package fire_ctrl_pkg;

    localparam int c_COOLDOWN_CYCLES_DEF = 8;
    localparam int c_ACK_TIMEOUT_DEF     = 4;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_ISSUE    = 3'd1;
    localparam logic [2:0] c_ST_COOLDOWN = 3'd2;
    localparam logic [2:0] c_ST_EMPTY    = 3'd3;
    localparam logic [2:0] c_ST_FAULT    = 3'd4;

    localparam logic c_REQ_PILOT = 1'b0;
    localparam logic c_REQ_AUTO  = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input combinational round-robin arbiter; on a tie the
//               requester not recorded in i_last_served wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import fire_ctrl_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_served,
    output logic       o_grant_idx,
    output logic       o_grant_valid
);

    always_comb begin
        o_grant_valid = |i_req;
        o_grant_idx   = c_REQ_PILOT;
        case (i_req)
            2'b01:   o_grant_idx = c_REQ_PILOT;
            2'b10:   o_grant_idx = c_REQ_AUTO;
            2'b11:   o_grant_idx = ~i_last_served;
            default: o_grant_idx = c_REQ_PILOT;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fire_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fire_request_scheduler
// Description : Arbitrates pilot/autonomous launch requests, holds
//               fire_command until acknowledged, then enforces a cooldown.
// Revision    : 1.0 - initial release
// ============================================================================
module fire_request_scheduler #(
    parameter int COOLDOWN_CYCLES = fire_ctrl_pkg::c_COOLDOWN_CYCLES_DEF,
    parameter int ACK_TIMEOUT     = fire_ctrl_pkg::c_ACK_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       target_locked,
    input  logic       pilot_req,
    input  logic       auto_req,
    input  logic       launch_missile,
    input  logic [3:0] remaining_missiles,
    output logic       fire_command,
    output logic       pilot_grant,
    output logic       auto_grant,
    output logic       busy,
    output logic       fault,
    output logic [2:0] sched_state
);

    import fire_ctrl_pkg::*;

    localparam int c_TIMER_W = $clog2(max2(COOLDOWN_CYCLES, ACK_TIMEOUT) + 1);
    localparam logic [c_TIMER_W-1:0] c_ACK_LAST = c_TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [c_TIMER_W-1:0] c_CD_LAST  = c_TIMER_W'(COOLDOWN_CYCLES - 1);

    logic [2:0]           state_q, state_d;
    logic [c_TIMER_W-1:0] timer_q, timer_d;
    logic                 winner_q, winner_d;
    logic                 last_served_q, last_served_d;
    logic                 fire_command_q, fire_command_d;
    logic                 pilot_grant_q, pilot_grant_d;
    logic                 auto_grant_q, auto_grant_d;
    logic                 busy_q, busy_d;
    logic                 fault_q, fault_d;

    logic                 w_grant_idx;
    logic                 w_grant_valid;
    logic                 w_ammo_empty;
    logic                 w_ack_commit;

    assign w_ammo_empty = (remaining_missiles == 4'd0);

    rr_arbiter2 u_arb (
        .i_req         ({auto_req, pilot_req}),
        .i_last_served (last_served_q),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= c_ST_IDLE;
            timer_q        <= '0;
            winner_q       <= c_REQ_PILOT;
            last_served_q  <= c_REQ_AUTO;
            fire_command_q <= 1'b0;
            pilot_grant_q  <= 1'b0;
            auto_grant_q   <= 1'b0;
            busy_q         <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            winner_q       <= winner_d;
            last_served_q  <= last_served_d;
            fire_command_q <= fire_command_d;
            pilot_grant_q  <= pilot_grant_d;
            auto_grant_q   <= auto_grant_d;
            busy_q         <= busy_d;
            fault_q        <= fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q + c_TIMER_W'(1);
        winner_d      = winner_q;
        last_served_d = last_served_q;
        case (state_q)
            c_ST_IDLE: begin
                // Ammo check outranks any pending request.
                if (w_ammo_empty) begin
                    state_d = c_ST_EMPTY;
                end else if (target_locked && w_grant_valid) begin
                    state_d  = c_ST_ISSUE;
                    winner_d = w_grant_idx;
                end
            end
            c_ST_ISSUE: begin
                if (!target_locked) begin
                    state_d = c_ST_IDLE;
                end else if (launch_missile) begin
                    state_d       = c_ST_COOLDOWN;
                    last_served_d = winner_q;
                end else if (timer_q == c_ACK_LAST) begin
                    state_d = c_ST_FAULT;
                end
            end
            c_ST_COOLDOWN: begin
                if (timer_q == c_CD_LAST) begin
                    state_d = w_ammo_empty ? c_ST_EMPTY : c_ST_IDLE;
                end
            end
            c_ST_EMPTY,
            c_ST_FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
        // Shared timer restarts on every state change and never runs while parked.
        if (state_d != state_q || state_d == c_ST_IDLE ||
            state_d == c_ST_EMPTY || state_d == c_ST_FAULT) begin
            timer_d = '0;
        end
    end

    always_comb begin
        w_ack_commit   = (state_q == c_ST_ISSUE) && (state_d == c_ST_COOLDOWN);
        fire_command_d = (state_d == c_ST_ISSUE);
        busy_d         = (state_d == c_ST_ISSUE) || (state_d == c_ST_COOLDOWN);
        fault_d        = (state_d == c_ST_FAULT);
        pilot_grant_d  = w_ack_commit && (winner_q == c_REQ_PILOT);
        auto_grant_d   = w_ack_commit && (winner_q == c_REQ_AUTO);
    end

    assign fire_command = fire_command_q;
    assign pilot_grant  = pilot_grant_q;
    assign auto_grant   = auto_grant_q;
    assign busy         = busy_q;
    assign fault        = fault_q;
    assign sched_state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fire_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fire_request_scheduler
// Description : Directed bench; expected grant events are queued by the
//               stimulus and consumed by a separate grant monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fire_request_scheduler;

    localparam int c_CD  = 8;
    localparam int c_ACK = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       target_locked;
    logic       pilot_req;
    logic       auto_req;
    logic       launch_missile;
    logic [3:0] remaining_missiles;
    logic       fire_command;
    logic       pilot_grant;
    logic       auto_grant;
    logic       busy;
    logic       fault;
    logic [2:0] sched_state;

    typedef struct {
        int id;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    fire_request_scheduler #(
        .COOLDOWN_CYCLES (c_CD),
        .ACK_TIMEOUT     (c_ACK)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .target_locked      (target_locked),
        .pilot_req          (pilot_req),
        .auto_req           (auto_req),
        .launch_missile     (launch_missile),
        .remaining_missiles (remaining_missiles),
        .fire_command       (fire_command),
        .pilot_grant        (pilot_grant),
        .auto_grant         (auto_grant),
        .busy               (busy),
        .fault              (fault),
        .sched_state        (sched_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_grant(input int id);
        exp_t e;
        e.id  = id;
        e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        pilot_req      = 1'b0;
        auto_req       = 1'b0;
        launch_missile = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_fire(input string name);
        int k;
        k = 0;
        while (!fire_command && k < 40) begin
            tick(1);
            k++;
        end
        chk(name, int'(fire_command), 1);
    endtask

    // Grant monitor: every grant pulse must match the head of the queue.
    always @(negedge clk) begin
        if (pilot_grant || auto_grant) begin
            exp_t e;
            chk("grant_onehot", int'(pilot_grant && auto_grant), 0);
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_grant: got pilot=%0d auto=%0d expected none at cyc %0d",
                         pilot_grant, auto_grant, cyc);
            end else begin
                e = q.pop_front();
                chk("grant_id", auto_grant ? 1 : 0, e.id);
                chk("grant_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int ack_edge;
        int ids[3];
        ids[0] = 0;
        ids[1] = 1;
        ids[2] = 0;
        ack_edge = 0;

        target_locked      = 1'b1;
        remaining_missiles = 4'd4;

        // Reset state and single pilot launch
        do_reset();
        chk("rst_state", int'(sched_state), 0);
        chk("rst_fire", int'(fire_command), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fault", int'(fault), 0);
        pilot_req = 1'b1;
        tick(1);
        chk("t1_issue_state", int'(sched_state), 1);
        chk("t1_fire", int'(fire_command), 1);
        chk("t1_busy", int'(busy), 1);
        pilot_req = 1'b0;
        tick(2);
        chk("t1_fire_held", int'(fire_command), 1);
        launch_missile = 1'b1;
        push_grant(0);
        tick(1);
        launch_missile = 1'b0;
        chk("t1_cd_state", int'(sched_state), 2);
        chk("t1_cd_fire", int'(fire_command), 0);
        tick(c_CD - 1);
        chk("t1_cd_busy_end", int'(busy), 1);
        tick(1);
        chk("t1_idle_state", int'(sched_state), 0);
        chk("t1_idle_busy", int'(busy), 0);

        // Tie, round robin, cooldown spacing
        do_reset();
        pilot_req = 1'b1;
        auto_req  = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            wait_fire("t2_fire_wait");
            if (i > 0) chk("t2_spacing", cyc - ack_edge, c_CD + 1);
            launch_missile = 1'b1;
            push_grant(ids[i]);
            tick(1);
            ack_edge = cyc;
            launch_missile = 1'b0;
        end
        pilot_req = 1'b0;
        auto_req  = 1'b0;
        tick(c_CD + 1);

        // Lock loss mid-ISSUE, then next tie goes to pilot
        do_reset();
        pilot_req = 1'b1;
        auto_req  = 1'b1;
        tick(1);
        chk("t3_issue", int'(sched_state), 1);
        target_locked = 1'b0;
        tick(1);
        chk("t3_abort_state", int'(sched_state), 0);
        chk("t3_abort_fire", int'(fire_command), 0);
        chk("t3_abort_fault", int'(fault), 0);
        target_locked = 1'b1;
        tick(1);
        chk("t3_reissue", int'(fire_command), 1);
        launch_missile = 1'b1;
        push_grant(0);
        tick(1);
        launch_missile = 1'b0;
        pilot_req = 1'b0;
        auto_req  = 1'b0;

        // Ack timeout
        do_reset();
        pilot_req = 1'b1;
        tick(1);
        tick(c_ACK - 1);
        chk("t4_still_issue", int'(sched_state), 1);
        tick(1);
        chk("t4_fault_state", int'(sched_state), 4);
        chk("t4_fault", int'(fault), 1);
        chk("t4_fire", int'(fire_command), 0);
        auto_req = 1'b1;
        launch_missile = 1'b1;
        tick(3);
        chk("t4_fault_sticky", int'(fault), 1);
        chk("t4_fire_off", int'(fire_command), 0);

        // Out of ammo in IDLE
        remaining_missiles = 4'd0;
        do_reset();
        pilot_req = 1'b1;
        tick(1);
        chk("t5_empty_state", int'(sched_state), 3);
        chk("t5_empty_fire", int'(fire_command), 0);
        remaining_missiles = 4'd2;
        tick(2);
        chk("t5_empty_sticky", int'(sched_state), 3);

        // Ammo runs out during cooldown
        do_reset();
        pilot_req = 1'b1;
        tick(1);
        launch_missile = 1'b1;
        push_grant(0);
        tick(1);
        launch_missile = 1'b0;
        pilot_req = 1'b0;
        tick(3);
        remaining_missiles = 4'd0;
        tick(c_CD - 4);
        chk("t5_cd_last", int'(sched_state), 2);
        tick(1);
        chk("t5_cd_to_empty", int'(sched_state), 3);
        chk("t5_cd_busy", int'(busy), 0);

        // Reset mid-cooldown, then a fresh request issues immediately
        remaining_missiles = 4'd4;
        do_reset();
        pilot_req = 1'b1;
        tick(1);
        launch_missile = 1'b1;
        push_grant(0);
        tick(1);
        launch_missile = 1'b0;
        pilot_req = 1'b0;
        tick(2);
        chk("t6_in_cd", int'(sched_state), 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6_rst_state", int'(sched_state), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_fire", int'(fire_command), 0);
        pilot_req = 1'b1;
        tick(1);
        chk("t6_fresh_fire", int'(fire_command), 1);
        launch_missile = 1'b1;
        push_grant(0);
        tick(1);
        launch_missile = 1'b0;
        pilot_req = 1'b0;
        tick(c_CD + 2);

        chk("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
